// File: rtl/gene_sweep_ctrl.sv
// gene_sweep_ctrl: sweeps initial states through an external gene-network map and
// classifies each trajectory's attractor with Brent's cycle detection.
// Optional feature macro: GENE_SWEEP_STEPS_EN (reports per-trajectory step count on res_steps).
module gene_sweep_ctrl #(
    parameter int MAX_STEPS = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] range_lo,
    input  logic [7:0] range_hi,
    output logic [7:0] net_x,
    input  logic [7:0] net_fx,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_init,
    output logic [1:0] res_kind,
    output logic [8:0] res_len,
    output logic [7:0] res_rep,
    output logic [9:0] res_steps,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;
    state_t state, state_nx;
    logic [7:0] hi, cur_init, hare, tortoise;
    logic [9:0] power, lam, steps, lam_inc;
    logic [10:0] steps_inc;
    logic detect, timeout, last;
    assign lam_inc   = lam + 10'd1;
    assign steps_inc = {1'b0, steps} + 11'd1;
    assign detect    = net_fx == tortoise;
    assign timeout   = steps_inc == 11'(MAX_STEPS);
    assign last      = cur_init == hi;
    assign net_x     = hare;
    assign busy      = state != IDLE;
    assign res_valid = state == REPORT;
    // state register; reset abandons any sweep in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next-state: an empty range never leaves IDLE, detection or timeout ends RUN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start && range_lo <= range_hi ? LOAD : IDLE;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = detect || timeout ? REPORT : RUN;
            REPORT:  state_nx = res_ready ? (last ? IDLE : LOAD) : REPORT;
            default: state_nx = IDLE;
        endcase
    end
`ifdef GENE_SWEEP_STEPS_EN
    logic [9:0] res_steps_q;
    assign res_steps = res_steps_q;
    // step count latched alongside the rest of the record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) res_steps_q <= '0;
        else if (state == RUN && (detect || timeout)) res_steps_q <= steps_inc[9:0];
    end
`else
    assign res_steps = '0;
`endif
    // sweep bookkeeping, Brent tortoise/hare walk and result record capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            cur_init <= '0;
            hare     <= '0;
            tortoise <= '0;
            power    <= '0;
            lam      <= '0;
            steps    <= '0;
            res_init <= '0;
            res_kind <= '0;
            res_len  <= '0;
            res_rep  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && range_lo > range_hi) done <= 1'b1;
                    else if (start) begin
                        hi       <= range_hi;
                        cur_init <= range_lo;
                    end
                end
                LOAD: begin
                    hare     <= cur_init;
                    tortoise <= cur_init;
                    power    <= 10'd1;
                    lam      <= '0;
                    steps    <= '0;
                end
                RUN: begin
                    hare  <= net_fx;
                    steps <= steps_inc[9:0];
                    lam   <= lam_inc;
                    if (detect) begin
                        res_init <= cur_init;
                        res_kind <= lam == 10'd0 ? 2'b00 : 2'b01;
                        res_len  <= lam_inc[8:0];
                        res_rep  <= net_fx;
                    end else begin
                        if (lam_inc == power) begin
                            tortoise <= net_fx;
                            power    <= {power[8:0], 1'b0};
                            lam      <= '0;
                        end
                        if (timeout) begin
                            res_init <= cur_init;
                            res_kind <= 2'b10;
                            res_len  <= '0;
                            res_rep  <= net_fx;
                        end
                    end
                end
                REPORT: begin
                    if (res_ready && last) done <= 1'b1;
                    else if (res_ready) cur_init <= cur_init + 8'd1;
                end
                default: done <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_gene_sweep_ctrl.sv
// tb_gene_sweep_ctrl: scoreboard bench for gene_sweep_ctrl against a software Brent model.
module tb_gene_sweep_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b1;
    logic [7:0] range_lo = '0, range_hi = '0, net_x, net_fx;
    logic busy, res_valid, done;
    logic [7:0] res_init, res_rep;
    logic [1:0] res_kind;
    logic [8:0] res_len;
    logic [9:0] res_steps;
    logic start4 = 1'b0, ready4 = 1'b1;
    logic [7:0] net_x4, net_fx4, init4, rep4;
    logic busy4, valid4, done4;
    logic [1:0] kind4;
    logic [8:0] len4;
    logic [9:0] steps4;
    int mode = 0;
    int n_checks = 0, n_fail = 0, done_cnt = 0;
    typedef struct packed {
        logic [7:0] init;
        logic [1:0] kind;
        logic [8:0] len;
        logic [7:0] rep;
        logic [9:0] steps;
    } rec_t;
    rec_t q[$];

    gene_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .range_lo(range_lo), .range_hi(range_hi),
        .net_x(net_x), .net_fx(net_fx), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_init(res_init), .res_kind(res_kind), .res_len(res_len),
        .res_rep(res_rep), .res_steps(res_steps), .done(done)
    );
    gene_sweep_ctrl #(.MAX_STEPS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .range_lo(8'd0), .range_hi(8'd0),
        .net_x(net_x4), .net_fx(net_fx4), .busy(busy4), .res_valid(valid4),
        .res_ready(ready4), .res_init(init4), .res_kind(kind4), .res_len(len4),
        .res_rep(rep4), .res_steps(steps4), .done(done4)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f(input logic [7:0] x, input int m);
        case (m)
            0:       return x;
            1:       return x + 8'd1;
            2:       return x ^ 8'd1;
            default: return x * x + 8'd1;
        endcase
    endfunction

    always_comb net_fx = f(net_x, mode);
    assign net_fx4 = net_x4 + 8'd1;

    function automatic rec_t model(input logic [7:0] init, input int m, input int maxs);
        rec_t r;
        logic [7:0] hare, tort, fx;
        int power, lam;
        hare = init; tort = init; power = 1; lam = 0;
        r = '0;
        r.init = init;
        for (int s = 1; s <= maxs; s++) begin
            fx = f(hare, m);
            if (fx == tort) begin
                r.len = 9'(lam + 1); r.kind = lam == 0 ? 2'b00 : 2'b01; r.rep = fx; r.steps = 10'(s);
                break;
            end
            if (s == maxs) begin
                r.len = 0; r.kind = 2'b10; r.rep = fx; r.steps = 10'(s);
                break;
            end
            if (lam + 1 == power) begin tort = fx; power = (power * 2) & 1023; lam = 0; end
            else lam++;
            hare = fx;
        end
`ifndef GENE_SWEEP_STEPS_EN
        r.steps = 0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_init"}, res_init, 0);
        check({tag, "_kind"}, res_kind, 0);
        check({tag, "_len"}, res_len, 0);
        check({tag, "_rep"}, res_rep, 0);
        check({tag, "_steps"}, res_steps, 0);
        check({tag, "_net_x"}, net_x, 0);
    endtask

    // scoreboard: every cycle a record is presented it must match the queue head
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (res_valid) begin
            if (q.size() == 0) check("unexpected_record", 1, 0);
            else begin
                check("res_init", res_init, q[0].init);
                check("res_kind", res_kind, q[0].kind);
                check("res_len", res_len, q[0].len);
                check("res_rep", res_rep, q[0].rep);
                check("res_steps", res_steps, q[0].steps);
                if (res_ready) void'(q.pop_front());
            end
        end
    end

    task automatic run_sweep(input logic [7:0] lo, input logic [7:0] hi, input int m, input bit stall);
        int d0, b;
        mode = m; range_lo = lo; range_hi = hi;
        if (lo <= hi) for (int i = lo; i <= hi; i++) q.push_back(model(8'(i), m, 1023));
        d0 = done_cnt;
        res_ready = !stall;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        range_lo = 8'd200; range_hi = 8'd0;
        if (lo > hi) begin
            check("empty_done_next_cycle", done, 1);
            check("empty_busy", busy, 0);
            @(posedge clk); #1 check("empty_done_one_cycle", done, 0);
        end else check("busy_after_start", busy, 1);
        if (stall) begin
            b = 0;
            while (!res_valid && b < 5000) begin @(posedge clk); #1 b++; end
            check("stall_valid_seen", res_valid, 1);
            repeat (20) @(posedge clk);
            #1 res_ready = 1'b1;
        end
        b = 0;
        while (done_cnt == d0 && b < 20000) begin @(posedge clk); b++; end
        check("sweep_done_in_budget", b < 20000, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("records_left", q.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;
        run_sweep(8'd5, 8'd5, 0, 1'b1);
        run_sweep(8'd0, 8'd0, 1, 1'b0);
        run_sweep(8'd254, 8'd255, 2, 1'b0);
        run_sweep(8'd10, 8'd3, 0, 1'b0);
        run_sweep(8'd0, 8'd15, 3, 1'b0);
        // reset in the middle of a long trajectory: no record may appear afterwards
        mode = 1; range_lo = 8'd0; range_hi = 8'd0;
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #2 check("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1 check_reset_outputs("mid_run_reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (600) @(posedge clk);
        #1 check("abandoned_busy", busy, 0);
        check("abandoned_done", done_cnt - d0, 0);
        // MAX_STEPS=4 instance times out after four RUN cycles
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); n = 1; #1 start4 = 1'b0;
        check("t4_busy", busy4, 1);
        while (!valid4 && n < 50) begin @(posedge clk); n++; #1; end
        check("t4_latency", n, 6);
        check("t4_init", init4, 0);
        check("t4_kind", kind4, 2);
        check("t4_len", len4, 0);
        check("t4_rep", rep4, 4);
`ifdef GENE_SWEEP_STEPS_EN
        check("t4_steps", steps4, 4);
`else
        check("t4_steps", steps4, 0);
`endif
        @(posedge clk); #1 check("t4_done", done4, 1);
        check("t4_net_x", net_x4, 4);
        @(posedge clk); #1 check("t4_idle", busy4, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
